response_bus_arbiter: RTL and testbench
=======================================

Name: response_bus_arbiter

Overview:
Arbitrates the shared response bus among N slaves, such as the on-chip ROM and RAM slaves, that return read data to bus masters. Each slave raises breq when it has a response queued. The slave then watches its bgnt and drives data/tag/oe with bhold asserted for its output cycle(s). The arbiter issues registered one-hot grants in round-robin order and keeps ownership until the owner drops both breq and bhold. A watchdog revokes grants that are held too long.

Parameters:
NUM_SLAVES, 4, number of response-bus slaves (2..16)
MAX_GRANT, 16, max consecutive cycles one owner may hold bgnt before forced revoke (>=3)

Ports:
clock  input  1  system clock, all state on rising edge
reset_n  input  1  synchronous, active-low reset
breq  input  NUM_SLAVES  per-slave bus request, level, held until granted
bhold  input  NUM_SLAVES  per-slave hold, asserted by owner while driving response bus
bgnt  output  NUM_SLAVES  one-hot (or zero) registered grant
bus_busy  output  1  high whenever any bgnt bit is high
owner  output  $clog2(NUM_SLAVES)  index of current grantee, valid when bus_busy
timeout_error  output  1  sticky, set on watchdog revoke, cleared only by reset

Behaviour:
- Reset (reset_n low at a rising edge): bgnt=0, bus_busy=0, owner=0, timeout_error=0, rr pointer=0, grant counter=0, state IDLE. Reset mid-grant drops bgnt on that edge with no drain.
- States: IDLE (no owner) and OWNED (exactly one bgnt bit high). All outputs are registered; there is no combinational path from breq/bhold to bgnt.
- IDLE: if any breq bit is high in cycle t, pick the first requester at or after rr pointer, wrapping modulo NUM_SLAVES. Set bgnt[k] and owner=k, and go to OWNED in cycle t+1. If no breq is high, stay in IDLE.
- OWNED, owner k: the release condition is breq[k]=0 and bhold[k]=0 in cycle t.
  - On release, the rr pointer becomes k+1 (mod N).
  - If another breq is high in the same cycle t, grant it in t+1 with no idle cycle. The search starts from the new pointer, so k itself is lowest priority.
  - Otherwise bgnt=0 in t+1 and the state returns to IDLE.
- While OWNED, breq from other slaves is ignored but remains pending. bhold from non-owners is ignored.
- Grant counter: cleared on each new grant and incremented each cycle bgnt is high. If the release condition is false when the counter reaches MAX_GRANT-1, the watchdog fires:
  - bgnt is revoked next cycle.
  - timeout_error is set.
  - the rr pointer advances past k.
  - re-arbitration follows the normal release rules.
  A revoked slave still requesting is eligible again only after all others.
- A grant is never issued to a slave whose breq is low in the arbitration cycle.
- Timing contract with a slave FSM (breq, then wait for bgnt, then one output cycle with bhold), for request in cycle 0:
  - cycle 1: bgnt high.
  - cycle 2: slave drives with bhold=1, breq=0.
  - cycle 3: slave idle, release seen.
  - cycle 4: bgnt low, or moved to next requester.
- The owner field holds its last value while IDLE.

Test Plan:
- Single request: N=4, breq=0010 at cycle 0 until bgnt seen; bhold[1]=1 in cycle 2 only -> bgnt=0010 in cycles 1-3, owner=1, bgnt=0000 from cycle 4, bus_busy tracks bgnt.
- Round robin: breq=0101 held continuously from reset release; each owner does breq->bhold 1 cycle->release -> grants alternate 0,2,0,2 with no idle cycle between owners.
- Fairness under contention: breq=1111 continuously, each owner releases after 2 cycles -> grant order 0,1,2,3,0 and each slave gets exactly one grant per 4.
- Late arrival during ownership: slave 0 owned; breq[3] rises mid-grant -> bgnt[3] asserted the cycle after slave 0 releases, never before.
- Watchdog: MAX_GRANT=16, slave 2 holds bhold[2]=1 forever -> bgnt[2] high exactly 16 cycles then drops, timeout_error=1 and stays 1. Pending breq[0] is granted the next cycle.
- Reset mid-operation: assert reset_n=0 while bgnt=1000 -> all outputs 0 after that edge. After release with breq=1001 -> first grant to slave 0 (pointer reset).

Source files
------------

// File: rtl/response_bus_arbiter.sv
// response_bus_arbiter: round-robin owner arbiter for a shared slave response bus with grant watchdog
//   clock         : system clock, all state on the rising edge
//   reset_n       : synchronous active-low reset
//   breq          : per-slave level request, held until granted
//   bhold         : per-slave hold, asserted by the owner while it drives the bus
//   bgnt          : registered one-hot (or zero) grant
//   bus_busy      : high while any grant is active
//   owner         : index of the current grantee, holds its last value while idle
//   timeout_error : sticky flag set when the watchdog revokes a grant
module response_bus_arbiter #(
  parameter int NUM_SLAVES = 4,
  parameter int MAX_GRANT = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_SLAVES-1:0]         breq,
  input  logic [NUM_SLAVES-1:0]         bhold,
  output logic [NUM_SLAVES-1:0]         bgnt,
  output logic                          bus_busy,
  output logic [$clog2(NUM_SLAVES)-1:0] owner,
  output logic                          timeout_error
);
  localparam int OW = $clog2(NUM_SLAVES);
  localparam int CW = $clog2(MAX_GRANT);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWNED = 1'b1;
  localparam logic [OW:0] NW = (OW+1)'(NUM_SLAVES);
  localparam logic [CW-1:0] CMAX = CW'(MAX_GRANT - 1);
  logic [0:0] state_q, state_d;
  logic [NUM_SLAVES-1:0] bgnt_q, bgnt_d;
  logic [OW-1:0] owner_q, owner_d, ptr_q, ptr_d, base, nxt, pick_idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW:0] j;
  logic terr_q, terr_d, owned, rel, wd, arb, pick_ok;
  assign owned = state_q == OWNED;
  assign rel = !breq[owner_q] && !bhold[owner_q];
  // cnt_q counts cycles already held minus one, so this fires on the MAX_GRANT-th held cycle
  assign wd = owned && !rel && cnt_q == CMAX;
  assign arb = !owned || rel || wd;
  assign nxt = (owner_q == OW'(NUM_SLAVES - 1)) ? '0 : owner_q + 1'b1;
  // leaving an owner moves the pointer past it, making it the lowest priority in this very search
  assign base = owned ? nxt : ptr_q;
  // descending scan so the requester closest to base is the last (winning) assignment
  always_comb begin
    pick_ok = 1'b0;
    pick_idx = '0;
    j = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      j = {1'b0, base} + (OW+1)'(i);
      j = (j >= NW) ? j - NW : j;
      if (breq[j[OW-1:0]]) begin
        pick_ok = 1'b1;
        pick_idx = j[OW-1:0];
      end
    end
  end
  assign state_d = arb ? (pick_ok ? OWNED : IDLE) : state_q;
  assign bgnt_d = arb ? (pick_ok ? NUM_SLAVES'(1) << pick_idx : '0) : bgnt_q;
  assign owner_d = (arb && pick_ok) ? pick_idx : owner_q;
  assign ptr_d = (owned && arb) ? nxt : ptr_q;
  assign cnt_d = arb ? '0 : cnt_q + 1'b1;
  assign terr_d = terr_q | wd;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      bgnt_q <= '0;
      owner_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      terr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bgnt_q <= bgnt_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      terr_q <= terr_d;
    end
  end
  assign bgnt = bgnt_q;
  assign bus_busy = owned;
  assign owner = owner_q;
  assign timeout_error = terr_q;
endmodule

// File: tb/tb_response_bus_arbiter.sv
// tb_response_bus_arbiter: vector table, slave-protocol sequences and random stimulus against a reference model
module tb_response_bus_arbiter;
  localparam int N = 4;
  localparam int MAXG = 16;
  logic clock = 1'b0;
  logic reset_n;
  logic [N-1:0] breq, bhold, bgnt;
  logic bus_busy, timeout_error;
  logic [1:0] owner;
  int total = 0;
  int passed = 0;
  int m_ptr, m_owner, m_held;
  bit m_owned, m_terr;
  int grants[$];
  int gaps;
  typedef struct {
    logic rn;
    logic [N-1:0] rq, hd, gnt;
    logic busy;
    logic [1:0] own;
    logic terr;
  } vec_t;
  vec_t tbl[$];
  always #5 clock = ~clock;
  response_bus_arbiter #(.NUM_SLAVES(N), .MAX_GRANT(MAXG)) dut (
    .clock(clock), .reset_n(reset_n), .breq(breq), .bhold(bhold),
    .bgnt(bgnt), .bus_busy(bus_busy), .owner(owner), .timeout_error(timeout_error)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  function automatic int search(input logic [N-1:0] r, input int b);
    for (int i = 0; i < N; i++) if (r[(b + i) % N]) return (b + i) % N;
    return -1;
  endfunction
  task automatic mstep(input logic rn, input logic [N-1:0] rq, input logic [N-1:0] hd);
    int g;
    if (!rn) begin
      m_owned = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_terr = 0;
    end else if (!m_owned) begin
      g = search(rq, m_ptr);
      if (g >= 0) begin m_owned = 1; m_owner = g; m_held = 1; end
    end else if ((!rq[m_owner] && !hd[m_owner]) || m_held == MAXG) begin
      if (rq[m_owner] || hd[m_owner]) m_terr = 1;
      m_ptr = (m_owner + 1) % N;
      g = search(rq, m_ptr);
      if (g >= 0) begin m_owner = g; m_held = 1; end
      else m_owned = 0;
    end else m_held++;
  endtask
  task automatic tick();
    @(posedge clock);
    mstep(reset_n, breq, bhold);
    #1;
    chk("model_bgnt", bgnt, m_owned ? (1 << m_owner) : 0);
    chk("model_busy", bus_busy, m_owned);
    chk("model_owner", owner, m_owner);
    chk("model_terr", timeout_error, m_terr);
  endtask
  task automatic do_reset();
    reset_n = 0; breq = '0; bhold = '0;
    tick();
    reset_n = 1;
  endtask
  function automatic vec_t v(input logic rn, input logic [N-1:0] rq, input logic [N-1:0] hd,
                             input logic [N-1:0] gnt, input logic busy, input logic [1:0] own, input logic terr);
    vec_t r;
    r.rn = rn; r.rq = rq; r.hd = hd; r.gnt = gnt; r.busy = busy; r.own = own; r.terr = terr;
    return r;
  endfunction
  task automatic run_slaves(input logic [N-1:0] act, input int hl, input int cycles);
    int st[N];
    int cn[N];
    logic [N-1:0] prev;
    grants.delete();
    gaps = 0;
    prev = bgnt;
    for (int i = 0; i < N; i++) begin st[i] = 0; cn[i] = 0; end
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < N; i++) begin
        breq[i] = act[i] && st[i] == 0;
        bhold[i] = st[i] == 1;
      end
      for (int i = 0; i < N; i++) begin
        if (act[i]) begin
          if (st[i] == 0 && bgnt[i]) begin st[i] = 1; cn[i] = hl; end
          else if (st[i] == 1) begin cn[i]--; if (cn[i] == 0) st[i] = 2; end
          else if (st[i] == 2) st[i] = 0;
        end
      end
      tick();
      if (bgnt != 0 && bgnt != prev) grants.push_back(int'(owner));
      if (bgnt == 0 && grants.size() > 0) gaps++;
      prev = bgnt;
    end
  endtask
  initial begin
    int n;
    bit stuck;
    reset_n = 0; breq = '0; bhold = '0;
    tbl.push_back(v(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(v(1, 4'b0010, 4'b0000, 4'b0010, 1, 1, 0));
    tbl.push_back(v(1, 4'b0010, 4'b0000, 4'b0010, 1, 1, 0));
    tbl.push_back(v(1, 4'b0000, 4'b0010, 4'b0010, 1, 1, 0));
    tbl.push_back(v(1, 4'b0000, 4'b0000, 4'b0000, 0, 1, 0));
    tbl.push_back(v(1, 4'b0000, 4'b0000, 4'b0000, 0, 1, 0));
    tbl.push_back(v(1, 4'b0001, 4'b0000, 4'b0001, 1, 0, 0));
    tbl.push_back(v(1, 4'b0001, 4'b0000, 4'b0001, 1, 0, 0));
    tbl.push_back(v(1, 4'b1000, 4'b0001, 4'b0001, 1, 0, 0));
    tbl.push_back(v(1, 4'b1000, 4'b0001, 4'b0001, 1, 0, 0));
    tbl.push_back(v(1, 4'b1000, 4'b0000, 4'b1000, 1, 3, 0));
    tbl.push_back(v(1, 4'b1000, 4'b1000, 4'b1000, 1, 3, 0));
    tbl.push_back(v(0, 4'b1001, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(v(1, 4'b1001, 4'b0000, 4'b0001, 1, 0, 0));
    tbl.push_back(v(1, 4'b1000, 4'b0001, 4'b0001, 1, 0, 0));
    tbl.push_back(v(1, 4'b1000, 4'b0000, 4'b1000, 1, 3, 0));
    tbl.push_back(v(1, 4'b0000, 4'b1000, 4'b1000, 1, 3, 0));
    tbl.push_back(v(1, 4'b0000, 4'b0000, 4'b0000, 0, 3, 0));
    foreach (tbl[k]) begin
      reset_n = tbl[k].rn; breq = tbl[k].rq; bhold = tbl[k].hd;
      tick();
      chk($sformatf("vec%0d_bgnt", k), bgnt, tbl[k].gnt);
      chk($sformatf("vec%0d_busy", k), bus_busy, tbl[k].busy);
      chk($sformatf("vec%0d_owner", k), owner, tbl[k].own);
      chk($sformatf("vec%0d_terr", k), timeout_error, tbl[k].terr);
    end
    do_reset();
    run_slaves(4'b0101, 1, 40);
    chk("rr_count", grants.size() >= 8, 1);
    for (int k = 0; k < 8 && k < grants.size(); k++) chk($sformatf("rr_order%0d", k), grants[k], (k % 2) * 2);
    chk("rr_gaps", gaps, 0);
    do_reset();
    run_slaves(4'b1111, 2, 60);
    chk("fair_count", grants.size() >= 8, 1);
    for (int k = 0; k < 8 && k < grants.size(); k++) chk($sformatf("fair_order%0d", k), grants[k], k % 4);
    chk("fair_gaps", gaps, 0);
    do_reset();
    breq = 4'b0100;
    tick();
    breq = 4'b0001; bhold = 4'b0100;
    n = 0;
    while (bgnt[2] && n < 40) begin n++; tick(); end
    chk("wd_hold_cycles", n, MAXG);
    chk("wd_next_grant", bgnt, 4'b0001);
    chk("wd_terr_set", timeout_error, 1);
    breq = '0;
    repeat (5) tick();
    chk("wd_terr_sticky", timeout_error, 1);
    chk("wd_idle", bgnt, 4'b0000);
    do_reset();
    chk("wd_terr_cleared", timeout_error, 0);
    stuck = 0;
    for (int c = 0; c < 600; c++) begin
      if (c % 40 == 0) stuck = 1'($urandom_range(0, 1));
      reset_n = $urandom_range(0, 99) != 0;
      breq = N'($urandom);
      bhold = stuck ? '1 : ($urandom_range(0, 1) != 0 ? N'($urandom) : '0);
      tick();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
